// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by uart_rx and uart_tx.
//   - BAUD_TABLE   : baud rate selected by the 3-bit baud_sel code
//   - baud_div()   : clock cycles per 16x oversample tick, rounded to nearest
//   - parity_mode_t: encoding of the 2-bit parity_mode input
//   - exp_parity() : parity bit expected for a data word under a mode
//   - uart_state_t : frame FSM states
package uart_pkg;

    localparam int unsigned DIV_W = 16;

    localparam int unsigned BAUD_TABLE [8] = '{
        9600, 19200, 38400, 57600, 115200, 230400, 460800, 921600
    };

    typedef enum logic [1:0] {
        PAR_SPACE = 2'b00,
        PAR_MARK  = 2'b01,
        PAR_EVEN  = 2'b10,
        PAR_ODD   = 2'b11
    } parity_mode_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    // round(clk_freq / (16 * baud)) in integer arithmetic
    function automatic int unsigned baud_div(int unsigned clk_freq, logic [2:0] sel);
        int unsigned baud;
        baud = BAUD_TABLE[sel];
        return (clk_freq + 8 * baud) / (16 * baud);
    endfunction

    // Unused upper data bits must be zero so the reduction covers only real bits
    function automatic logic exp_parity(parity_mode_t mode, logic [7:0] word);
        logic p;
        case (mode)
            PAR_ODD:  p = ~^word;
            PAR_EVEN: p = ^word;
            PAR_MARK: p = 1'b1;
            default:  p = 1'b0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/uart_rx_baudgen.sv
// uart_rx_baudgen: 16x oversample tick generator for the UART receiver.
// Parameters:
//   CLK_FREQ  system clock frequency in Hz
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   restart   restarts the tick period (start-bit detection)
//   baud_sel  3-bit rate code, indexes the divisor table
//   tick      one-cycle 16x oversample enable
module uart_rx_baudgen
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 100_000_000
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       restart,
    input  logic [2:0] baud_sel,
    output logic       tick
);

    // Divisors are elaboration-time constants; only the table lookup is logic.
    logic [DIV_W-1:0] div_tab [8];

    for (genvar i = 0; i < 8; i++) begin : g_div
        assign div_tab[i] = DIV_W'(baud_div(CLK_FREQ, 3'(i)));
    end

    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] cnt;
    logic             wrap;

    assign div  = div_tab[baud_sel];
    assign wrap = (cnt >= div - 1'b1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (restart || wrap) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = wrap && !restart;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver, 7/8 data bits, optional parity, 1/2 stop bits,
// 16x oversampling, eight selectable baud rates.
// Build option: define UART_RX_MAJORITY_EN to take each bit as the 2-of-3
// majority of samples at ticks 7, 8, 9 (decided at tick 9) instead of a
// single sample at tick 8.
// Parameters:
//   CLK_FREQ       system clock frequency in Hz
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous active-high reset
//   en             receiver enable; dropping it mid-frame aborts the frame
//   baud_sel       rate code 0..7 = 9600 .. 921600
//   data_size      0: 7 data bits, 1: 8 data bits
//   parity_en      parity bit present
//   parity_mode    11 odd, 10 even, 01 mark, 00 space
//   stop_bit_size  0: one stop bit, 1: two stop bits
//   rx             asynchronous serial line, idle high
//   data           received word (bit7 = 0 in 7-bit mode), held until next valid
//   valid          one-cycle pulse marking a new word
//   parity_err     parity mismatch for the word flagged by valid
//   frame_err      a stop bit was sampled 0 for the word flagged by valid
//   busy           high from start-bit detection until return to IDLE
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 100_000_000
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [2:0] baud_sel,
    input  logic       data_size,
    input  logic       parity_en,
    input  logic [1:0] parity_mode,
    input  logic       stop_bit_size,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    // Every bit decision happens when tick_cnt wraps 15->0. Presetting the
    // counter at start detection places that first wrap at the start-bit
    // decision tick; all later decisions then fall 16 ticks apart.
`ifdef UART_RX_MAJORITY_EN
    localparam logic [3:0] TICK_PRESET = 4'd7;
`else
    localparam logic [3:0] TICK_PRESET = 4'd8;
`endif

    uart_state_t state, state_nxt;

    logic         rx_meta, rx_s, rx_prev;
    logic         start_det;
    logic         tick;
    logic [3:0]   tick_cnt;
    logic         samp_now;
    logic         samp_bit;
    logic [2:0]   bit_cnt;
    logic         stop_cnt;
    logic         last_data_bit;
    logic         last_stop_bit;
    logic         frame_done;
    logic [7:0]   shreg;
    logic [7:0]   word;
    logic         par_err_r;
    logic         frm_err_r;

    logic [2:0]   baud_l;
    logic         ds_l;
    logic         pen_l;
    parity_mode_t pm_l;
    logic         stop2_l;

    // Synchronizer plus one history flop for falling-edge detection; all idle high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    assign start_det = (state == IDLE) && en && rx_prev && !rx_s;

    uart_rx_baudgen #(
        .CLK_FREQ (CLK_FREQ)
    ) u_baudgen (
        .clk      (clk),
        .rst      (rst),
        .restart  (start_det),
        .baud_sel (baud_l),
        .tick     (tick)
    );

    assign samp_now = tick && (tick_cnt == 4'd15);

`ifdef UART_RX_MAJORITY_EN
    logic samp_a, samp_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            samp_a <= 1'b1;
            samp_b <= 1'b1;
        end else if (tick) begin
            if (tick_cnt == 4'd13) samp_a <= rx_s;
            if (tick_cnt == 4'd14) samp_b <= rx_s;
        end
    end

    assign samp_bit = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);
`else
    assign samp_bit = rx_s;
`endif

    assign last_data_bit = (bit_cnt == (ds_l ? 3'd7 : 3'd6));
    assign last_stop_bit = stop_cnt || !stop2_l;
    assign frame_done    = (state == STOP) && samp_now && last_stop_bit && en;

    // 7-bit words enter at bit7 and end up in shreg[7:1]
    assign word = ds_l ? shreg : {1'b0, shreg[7:1]};

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_det) state_nxt = START;
            START:   if (samp_now) state_nxt = samp_bit ? IDLE : DATA;
            DATA:    if (samp_now && last_data_bit) state_nxt = pen_l ? PARITY : STOP;
            PARITY:  if (samp_now) state_nxt = STOP;
            STOP:    if (samp_now && last_stop_bit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (!en && (state != IDLE)) begin
            state_nxt = IDLE;
        end
    end

    // Output logic
    always_comb begin
        busy = (state != IDLE);
    end

    // Frame datapath: config latch, bit counters, shift register, result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            shreg      <= '0;
            par_err_r  <= 1'b0;
            frm_err_r  <= 1'b0;
            baud_l     <= '0;
            ds_l       <= 1'b0;
            pen_l      <= 1'b0;
            pm_l       <= PAR_SPACE;
            stop2_l    <= 1'b0;
            data       <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            valid <= 1'b0;

            if (start_det) begin
                baud_l    <= baud_sel;
                ds_l      <= data_size;
                pen_l     <= parity_en;
                pm_l      <= parity_mode_t'(parity_mode);
                stop2_l   <= stop_bit_size;
                tick_cnt  <= TICK_PRESET;
                bit_cnt   <= '0;
                stop_cnt  <= 1'b0;
                par_err_r <= 1'b0;
                frm_err_r <= 1'b0;
            end else if (tick) begin
                tick_cnt <= tick_cnt + 1'b1;
            end

            if (samp_now) begin
                case (state)
                    DATA: begin
                        shreg   <= {samp_bit, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    PARITY: begin
                        par_err_r <= (samp_bit != exp_parity(pm_l, word));
                    end
                    STOP: begin
                        stop_cnt <= 1'b1;
                        if (!samp_bit) frm_err_r <= 1'b1;
                    end
                    default: ;
                endcase
            end

            if (frame_done) begin
                data       <= word;
                parity_err <= par_err_r;
                frame_err  <= frm_err_r | !samp_bit;
                valid      <= 1'b1;
            end
        end
    end

endmodule
